// File: rtl/rr_arbiter_8_pkg.sv
// rr_arbiter_8_pkg: shared sizes and FSM encodings for the 8-way round-robin arbiter
package rr_arbiter_8_pkg;
    localparam int N_REQ = 8;
    localparam int IDXW  = 3;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;
endpackage

// File: rtl/decoder_3to8_en.sv
// decoder_3to8_en: 3-to-8 one-hot decoder with active-high enable
module decoder_3to8_en (
    input  logic [2:0] inp,
    input  logic       enab,
    output logic [7:0] y
);
    assign y = enab ? (8'd1 << inp) : 8'd0;
endmodule

// File: rtl/rr_pick_8.sv
// rr_pick_8: first requester after last_idx, with wrap, so the last winner is checked last
module rr_pick_8
    import rr_arbiter_8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDXW-1:0]  last_idx,
    output logic [IDXW-1:0]  win_idx,
    output logic             any_req
);
    logic [IDXW-1:0] idx;
    logic            found;
    always_comb begin
        win_idx = '0;
        idx     = '0;
        found   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = last_idx + IDXW'(k);
            if (!found && req[idx]) begin
                win_idx = idx;
                found   = 1'b1;
            end
        end
    end
    assign any_req = |req;
endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter, hold-until-release grants, one-cycle gap, max-hold timeout
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int HOLDW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDXW-1:0]  gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);
    state_t           state, state_nx;
    logic [IDXW-1:0]  last_idx, win_idx;
    logic [HOLDW-1:0] hold_cnt;
    logic             any_req, quit, hit, rel;

    rr_pick_8 u_pick (
        .req      (req),
        .last_idx (last_idx),
        .win_idx  (win_idx),
        .any_req  (any_req)
    );

    decoder_3to8_en u_dec (
        .inp  (gnt_idx),
        .enab (gnt_vld),
        .y    (gnt)
    );

    assign quit = done || !req[gnt_idx];
    assign hit  = hold_cnt == HOLDW'(MAX_HOLD - 1);
    assign rel  = (state == ST_BUSY) && (quit || hit);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: state_nx = any_req ? ST_BUSY : ST_IDLE;
            ST_BUSY: state_nx = rel ? ST_GAP : ST_BUSY;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt_vld  <= 1'b0;
            gnt_idx  <= '0;
            timeout  <= 1'b0;
            last_idx <= IDXW'(N_REQ - 1);
            hold_cnt <= '0;
        end else begin
            state   <= state_nx;
            // a timeout is flagged only when the hold limit was the sole cause
            timeout <= rel && !quit;
            if (state == ST_IDLE && any_req) begin
                gnt_idx  <= win_idx;
                gnt_vld  <= 1'b1;
                hold_cnt <= '0;
                last_idx <= win_idx;
            end
            if (state == ST_BUSY) begin
                if (rel) gnt_vld <= 1'b0;
                else hold_cnt <= hold_cnt + HOLDW'(1);
            end
        end
    end
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed scenarios plus random traffic checked against a cycle-level model
module tb_rr_arbiter_8;
    localparam int MAX_HOLD = 4;

    logic       clk = 0;
    logic       rst_n = 0;
    logic [7:0] req = 0;
    logic       done = 0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int n_tot = 0;
    int n_fail = 0;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .HOLDW(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // model: owner / held-cycle count / gap flag, updated from inputs seen at each edge
    bit busy = 0, gap = 0, m_to = 0;
    int owner = 0, last = 7, held = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            busy = 0; gap = 0; m_to = 0; owner = 0; last = 7; held = 0;
        end else if (busy) begin
            bit q, h;
            held++;
            h = held == MAX_HOLD;
            q = done || !req[owner];
            if (q || h) begin
                busy = 0; gap = 1; m_to = h && !q;
            end
        end else if (gap) begin
            gap = 0; m_to = 0;
        end else begin
            m_to = 0;
            for (int k = 1; k <= 8; k++) begin
                if (!busy && req[(last + k) % 8]) begin
                    busy = 1; owner = (last + k) % 8; last = owner; held = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("model_gnt", 32'(gnt), busy ? 32'(1) << owner : 32'd0);
        chk("model_vld", 32'(gnt_vld), 32'(busy));
        chk("model_idx", 32'(gnt_idx), 32'(owner));
        chk("model_timeout", 32'(timeout), 32'(m_to));
        chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
    end

    task automatic step(input logic [7:0] r, input logic d, input logic rn);
        req = r; done = d; rst_n = rn;
        @(posedge clk);
        #2;
    endtask

    initial begin
        // reset with all requesting
        for (int i = 0; i < 2; i++) begin
            step(8'hFF, 1'b0, 1'b0);
            chk("rst_gnt", 32'(gnt), 32'h00);
            chk("rst_vld", 32'(gnt_vld), 32'd0);
            chk("rst_idx", 32'(gnt_idx), 32'd0);
            chk("rst_to", 32'(timeout), 32'd0);
        end
        // release via done and regrant
        step(8'h20, 1'b0, 1'b1);
        chk("t2_gnt", 32'(gnt), 32'h20);
        chk("t2_idx", 32'(gnt_idx), 32'd5);
        step(8'h20, 1'b1, 1'b1);
        chk("t2_rel", 32'(gnt), 32'h00);
        step(8'h20, 1'b0, 1'b1);
        chk("t2_gap", 32'(gnt), 32'h00);
        step(8'h20, 1'b0, 1'b1);
        chk("t2_regnt", 32'(gnt), 32'h20);
        // round-robin order
        step(8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(8'hFF, 1'b0, 1'b1);
            chk("t3_order", 32'(gnt), 32'd1 << (i % 8));
            step(8'hFF, 1'b1, 1'b1);
            chk("t3_rel", 32'(gnt), 32'h00);
            step(8'hFF, 1'b0, 1'b1);
            chk("t3_gap", 32'(gnt), 32'h00);
        end
        // hold-limit timeout
        step(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(8'h0C, 1'b0, 1'b1);
            chk("t4_hold", 32'(gnt), 32'h04);
            chk("t4_noto", 32'(timeout), 32'd0);
        end
        step(8'h0C, 1'b0, 1'b1);
        chk("t4_rel", 32'(gnt), 32'h00);
        chk("t4_to", 32'(timeout), 32'd1);
        step(8'h0C, 1'b0, 1'b1);
        chk("t4_to_end", 32'(timeout), 32'd0);
        step(8'h0C, 1'b0, 1'b1);
        chk("t4_next", 32'(gnt), 32'h08);
        // done coinciding with the hold limit
        step(8'h00, 1'b0, 1'b0);
        step(8'h0C, 1'b0, 1'b1);
        step(8'h0C, 1'b0, 1'b1);
        step(8'h0C, 1'b0, 1'b1);
        step(8'h0C, 1'b0, 1'b1);
        chk("t5_busy", 32'(gnt), 32'h04);
        step(8'h0C, 1'b1, 1'b1);
        chk("t5_rel", 32'(gnt), 32'h00);
        chk("t5_noto", 32'(timeout), 32'd0);
        // request dropped mid-grant
        step(8'h00, 1'b0, 1'b0);
        step(8'h02, 1'b0, 1'b1);
        chk("t5b_gnt", 32'(gnt), 32'h02);
        step(8'h00, 1'b0, 1'b1);
        chk("t5b_rel", 32'(gnt), 32'h00);
        chk("t5b_noto", 32'(timeout), 32'd0);
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        chk("t5b_idle", 32'(gnt), 32'h00);
        // reset mid-grant
        step(8'h10, 1'b0, 1'b1);
        chk("t6_gnt", 32'(gnt), 32'h10);
        step(8'h10, 1'b0, 1'b0);
        chk("t6_rst", 32'(gnt), 32'h00);
        chk("t6_noto", 32'(timeout), 32'd0);
        step(8'h11, 1'b0, 1'b1);
        chk("t6_first", 32'(gnt), 32'h01);
        // random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] r;
            r = req;
            for (int b = 0; b < 8; b++) begin
                if (!r[b] && $urandom_range(3) == 0) r[b] = 1'b1;
                else if (r[b] && $urandom_range(15) == 0) r[b] = 1'b0;
            end
            step(r, $urandom_range(7) == 0, $urandom_range(99) != 0);
        end
        $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
        $finish;
    end
endmodule
